// File: rtl/preempt_timer_ctx.sv
// Preemption quantum timer with IRQ handshake and register-file context save/restore sequencer.
// Define PREEMPT_TIMER_STATS_EN to add the saturating expiry counter (irq_count_o, stats_clr_i).
module preempt_timer_ctx #(
   parameter int unsigned QUANTUM_W       = 16,
   parameter int unsigned DEFAULT_QUANTUM = 1000,
   parameter int unsigned NREGS           = 32,
   parameter int unsigned REG_AW          = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 os_usage_i,
   input  logic                 quantum_wr_i,
   input  logic [QUANTUM_W-1:0] quantum_din_i,
   input  logic                 irq_ack_i,
   input  logic                 restore_req_i,
`ifdef PREEMPT_TIMER_STATS_EN
   input  logic                 stats_clr_i,
   output logic [15:0]          irq_count_o,
`endif
   output logic                 timer_irq_o,
   output logic                 clear_irq_o,
   output logic                 ctx_busy_o,
   output logic [REG_AW-1:0]    ctx_addr_o,
   output logic                 ctx_we_o,
   output logic                 ctx_re_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAVE    = 2'd1,
      ST_RESTORE = 2'd2
   } state_e;

   localparam logic [REG_AW-1:0]    LAST_IDX    = REG_AW'(NREGS - 1);
   localparam logic [QUANTUM_W-1:0] QUANTUM_RST = QUANTUM_W'(DEFAULT_QUANTUM);

   state_e                state_q, state_d;
   logic [REG_AW-1:0]     idx_q, idx_d;
   logic                  pend_q, pend_d;
   logic                  os_q;
   logic [QUANTUM_W-1:0]  quantum_q, quantum_d;
   logic [QUANTUM_W-1:0]  cnt_q, cnt_d;
   logic                  irq_q, irq_d;
   logic                  clr_q, clr_d;
   logic                  os_rise;
   logic                  idle;
   logic                  expiry;

   assign os_rise = os_usage_i & ~os_q;
   assign idle    = (state_q == ST_IDLE);
   // The count only runs while the sequencer is idle, so expiry can only happen there.
   assign expiry  = ~os_usage_i & idle & (cnt_q == QUANTUM_W'(1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         pend_q    <= 1'b0;
         os_q      <= 1'b0;
         quantum_q <= QUANTUM_RST;
         cnt_q     <= '0;
         irq_q     <= 1'b0;
         clr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pend_q    <= pend_d;
         os_q      <= os_usage_i;
         quantum_q <= quantum_d;
         cnt_q     <= cnt_d;
         irq_q     <= irq_d;
         clr_q     <= clr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pend_d  = pend_q;
      case (state_q)
         ST_IDLE: begin
            idx_d = '0;
            if (os_rise) begin
               state_d = ST_SAVE;
               if (restore_req_i) pend_d = 1'b1;
            end else if (restore_req_i || pend_q) begin
               state_d = ST_RESTORE;
               pend_d  = 1'b0;
            end
         end
         ST_SAVE: begin
            if (restore_req_i) pend_d = 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d = '0;
               if (pend_q || restore_req_i) begin
                  state_d = ST_RESTORE;
                  pend_d  = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               idx_d = idx_q + REG_AW'(1);
            end
         end
         ST_RESTORE: begin
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + REG_AW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      ctx_busy_o = (state_q != ST_IDLE);
      ctx_we_o   = (state_q == ST_SAVE);
      ctx_re_o   = (state_q == ST_RESTORE);
      ctx_addr_o = ctx_busy_o ? idx_q : '0;
   end

   // A quantum write only changes the register; the running count picks it up at the next reload.
   always_comb begin
      quantum_d = quantum_wr_i ? quantum_din_i : quantum_q;
      if (os_usage_i) begin
         cnt_d = quantum_q;
      end else if (idle && (cnt_q != '0)) begin
         cnt_d = cnt_q - QUANTUM_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_comb begin
      irq_d = irq_q;
      clr_d = 1'b0;
      if (expiry) begin
         irq_d = 1'b1;
      end else if (irq_ack_i && irq_q) begin
         irq_d = 1'b0;
         clr_d = 1'b1;
      end
   end

   assign timer_irq_o = irq_q;
   assign clear_irq_o = clr_q;

`ifdef PREEMPT_TIMER_STATS_EN
   logic [15:0] irq_count_q, irq_count_d;

   always_comb begin
      irq_count_d = irq_count_q;
      if (stats_clr_i) begin
         irq_count_d = expiry ? 16'd1 : 16'd0;
      end else if (expiry && (irq_count_q != 16'hFFFF)) begin
         irq_count_d = irq_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) irq_count_q <= '0;
      else         irq_count_q <= irq_count_d;
   end

   assign irq_count_o = irq_count_q;
`endif

endmodule
